dm_sram_arbiter: RTL and testbench
==================================

Name: dm_sram_arbiter

Overview:
- Shares the single-port data-memory SRAM wrapper (16K x 32-bit words) between two requesters: port 0 = CPU load/store unit, port 1 = loader/DMA engine.
- Arbitrates per cycle with round-robin priority and supports a lock for read-modify-write sequences.
- Drives the SRAM's active-low CEB/WEB/BWEB controls.
- Routes next-cycle read data back to the requester that issued the read.

Parameters:
ADDR_W, 14, word-address width (16384 words)
DATA_W, 32, data width; must be multiple of 8
STRB_W, DATA_W/8, byte-strobe width
LOCK_MAX, 4, max consecutive locked grants before lock is ignored for one arbitration

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
m0_req  input  1  port 0 access request
m0_we  input  1  1 = write, 0 = read
m0_addr  input  ADDR_W  word address
m0_wstrb  input  STRB_W  byte write strobes (active-high)
m0_wdata  input  DATA_W  write data
m0_lock  input  1  keep grant on next cycle if still requesting
m0_gnt  output  1  request accepted this cycle (combinational)
m0_rvalid  output  1  read data valid (one cycle after granted read)
m0_rdata  output  DATA_W  read data; 0 when m0_rvalid=0
m1_*  same nine signals for port 1
sram_ceb  output  1  chip enable, active-low
sram_web  output  1  write enable, active-low
sram_bweb  output  DATA_W  bit write enable, active-low
sram_a  output  ADDR_W  SRAM address
sram_di  output  DATA_W  SRAM write data
sram_do  input  DATA_W  SRAM read data, valid one cycle after read issue

Behaviour:
- Reset: asynchronous, active-high, on rst. While rst=1, both gnt=0, both rvalid=0, both rdata=0, sram_ceb=1, sram_web=1, sram_bweb=all 1, sram_a=0, sram_di=0. Internal state resets to last_gnt=1, lock_owner=none, lock_cnt=0, rd_pend=0.
- Grant is combinational in the request cycle. At most one gnt per cycle.
  - One requester only: it is granted.
  - Both requesting with no active lock: grant the port not in last_gnt. After reset, port 0 wins the first conflict.
  - Active lock: the lock owner is granted if it is requesting.
- last_gnt updates on every grant.
- Lock:
  - A granted port with lock=1 becomes lock_owner, and lock_cnt increments.
  - Lock is released when the owner drops req or lock, or when lock_cnt reaches LOCK_MAX. At LOCK_MAX the next conflict follows plain round-robin and lock_cnt clears.
- SRAM drive in the grant cycle:
  - sram_ceb=0, sram_a=addr.
  - Write: sram_web=0, sram_di=wdata, sram_bweb[8i+7:8i]=~{8{wstrb[i]}}. A write with wstrb=0 still issues, with all BWEB bits 1.
  - Read: sram_web=1, sram_bweb=all 1, sram_di=0.
  - No grant: idle values as in reset.
- Read return:
  - A granted read sets rd_pend=1 and rd_id=port.
  - The next cycle, mX_rvalid=1 for rd_id, with mX_rdata=sram_do.
  - Reads issue back-to-back every cycle with no bubble. Writes produce no response.
- No write-to-read forwarding. A read the cycle after a write to the same address returns the written data via the SRAM itself.
- Reset mid-read: rd_pend clears and no rvalid is produced after reset release.
- Latency: grant 0 cycles, read data 1 cycle, throughput 1 access/cycle.

Optional Feature:
- Macro DM_ARB_PERF_EN.
- When defined, adds output ports perf_gnt0, perf_gnt1, perf_conflict (32 bits each):
  - perf_gnt0/perf_gnt1 count grants per port.
  - perf_conflict counts cycles where both req=1.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, these ports and counters are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- Package dm_arb_pkg holds:
  - ADDR_W, DATA_W, STRB_W constants.
  - typedef port_id_t (1 bit).
  - struct mem_req_t {we, addr, wstrb, wdata, lock}.
  - function strb_to_bweb().
- One sub-module, dm_arb_rr: two-way round-robin picker with lock. Inputs req[1:0], lock, last_gnt, lock_owner, lock_cnt; output one-hot gnt.

Test Plan:
- Port 0 only: write addr 0x3FFF, wdata 0xFFFF_FFFF, wstrb 4'hF; then read 0x3FFF -> gnt same cycle; sram_web=0 then 1; m0_rvalid one cycle after the read grant with rdata 0xFFFF_FFFF; m1_rvalid stays 0.
- Both ports request reads every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each rvalid goes to the correct port one cycle later with matching data.
- Port 1 holds lock=1 and req=1 while port 0 also requests, with LOCK_MAX=4 -> port 1 granted 4 consecutive cycles, then port 0 granted.
- Write wdata 0x1122_3344 with wstrb 4'b0101 over an existing word 0xAAAA_AAAA -> sram_bweb=0xFF00_FF00; a subsequent read returns 0xAA22_AA44.
- Assert rst in the cycle after a granted read -> no rvalid on either port; all outputs at reset values; the first post-reset conflict is granted to port 0.
- With DM_ARB_PERF_EN defined, run 10 conflict cycles -> perf_conflict=10 and perf_gnt0=perf_gnt1=5.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared widths, request record and byte-strobe helper for the data-memory SRAM arbiter.
package dm_arb_pkg;

    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 32;
    localparam int STRB_W       = DATA_W / 8;
    localparam int LOCK_MAX_DEF = 4;

    typedef logic port_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } mem_req_t;

    // SRAM bit-write-enable is active-low: a set strobe opens its whole byte lane.
    function automatic logic [DATA_W-1:0] strb_to_bweb(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] bweb;
        for (int i = 0; i < STRB_W; i++) begin
            bweb[8*i +: 8] = {8{~strb[i]}};
        end
        return bweb;
    endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker; an active, unexpired lock pins the grant to its owner.
module dm_arb_rr
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int CNT_W    = $clog2(LOCK_MAX + 1)
) (
    input  logic [1:0]       req,
    input  logic             lock,
    input  port_id_t         last_gnt,
    input  port_id_t         lock_owner,
    input  logic [CNT_W-1:0] lock_cnt,
    output logic [1:0]       gnt
);

    logic lock_hold;

    always_comb begin
        lock_hold = lock && (lock_cnt < CNT_W'(LOCK_MAX)) && req[lock_owner];
        gnt       = 2'b00;
        if (lock_hold) begin
            gnt[lock_owner] = 1'b1;
        end else if (req == 2'b11) begin
            gnt[~last_gnt] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dm_sram_arbiter.sv
// Shares the 16K x 32 data-memory SRAM between the CPU LSU (port 0) and loader/DMA (port 1).
// Optional saturating grant/conflict counters are built when DM_ARB_PERF_EN is defined.
module dm_sram_arbiter
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
`ifdef DM_ARB_PERF_EN
   ,output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    port_id_t         last_gnt;
    port_id_t         lock_owner;
    port_id_t         rd_id;
    port_id_t         gnt_id;
    logic             lock_vld;
    logic [CNT_W-1:0] lock_cnt;
    logic             rd_pend;
    logic [1:0]       pick;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             lock_cont;
    mem_req_t         req0;
    mem_req_t         req1;
    mem_req_t         sel;

    assign req0 = '{we: m0_we, addr: m0_addr, wstrb: m0_wstrb, wdata: m0_wdata, lock: m0_lock};
    assign req1 = '{we: m1_we, addr: m1_addr, wstrb: m1_wstrb, wdata: m1_wdata, lock: m1_lock};

    dm_arb_rr #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_rr (
        .req        ({m1_req, m0_req}),
        .lock       (lock_vld),
        .last_gnt   (last_gnt),
        .lock_owner (lock_owner),
        .lock_cnt   (lock_cnt),
        .gnt        (pick)
    );

    // Grants are combinational, so they must be forced off while reset is held.
    assign gnt     = rst ? 2'b00 : pick;
    assign any_gnt = |gnt;
    assign gnt_id  = gnt[1];
    assign sel     = gnt_id ? req1 : req0;
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (any_gnt) begin
            sram_ceb = 1'b0;
            sram_a   = sel.addr;
            if (sel.we) begin
                sram_web  = 1'b0;
                sram_bweb = strb_to_bweb(sel.wstrb);
                sram_di   = sel.wdata;
            end
        end
    end

    // A fresh lock (new owner, or after hitting the limit) restarts the streak at one.
    assign lock_cont = lock_vld && (lock_owner == gnt_id) && (lock_cnt < CNT_W'(LOCK_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt   <= 1'b1;
            lock_vld   <= 1'b0;
            lock_owner <= 1'b0;
            lock_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            rd_pend <= any_gnt && !sel.we;
            if (any_gnt) begin
                rd_id    <= gnt_id;
                last_gnt <= gnt_id;
            end
            if (any_gnt && sel.lock) begin
                lock_vld   <= 1'b1;
                lock_owner <= gnt_id;
                lock_cnt   <= lock_cont ? lock_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    assign m0_rvalid = rd_pend && (rd_id == 1'b0);
    assign m1_rvalid = rd_pend && (rd_id == 1'b1);
    assign m0_rdata  = m0_rvalid ? sram_do : '0;
    assign m1_rdata  = m1_rvalid ? sram_do : '0;

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else begin
            if (gnt[0] && perf_gnt0 != '1) perf_gnt0 <= perf_gnt0 + 32'd1;
            if (gnt[1] && perf_gnt1 != '1) perf_gnt1 <= perf_gnt1 + 32'd1;
            if (m0_req && m1_req && perf_conflict != '1) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_sram_arbiter.sv
// Bench for dm_sram_arbiter: directed vector table, then randomized traffic against a reference model.
module tb_dm_sram_arbiter;

    localparam int LOCK_MAX = 4;
    localparam int N_RANDOM = 600;
    localparam logic [13:0] ADR_A = 14'h3FFF;
    localparam logic [13:0] ADR_B = 14'h0100;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [13:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } port_in_t;

    typedef struct packed {
        logic     rst;
        port_in_t p0;
        port_in_t p1;
    } stim_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        ceb;
        logic        web;
        logic [31:0] bweb;
        logic [13:0] a;
        logic [31:0] di;
        logic [1:0]  rv;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [13:0] m0_addr;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [13:0] m1_addr;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_wdata, m1_rdata;
    logic        sram_ceb, sram_web;
    logic [31:0] sram_bweb, sram_di, sram_do;
    logic [13:0] sram_a;
`ifdef DM_ARB_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    int vectors     = 0;
    int miscompares = 0;

    dm_sram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wstrb  (m0_wstrb),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wstrb  (m1_wstrb),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_bweb (sram_bweb),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
`ifdef DM_ARB_PERF_EN
       ,.perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with active-low bit write enables and registered read data.
    bit [31:0] sram_mem [16384];
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
            else           sram_do <= sram_mem[sram_a];
        end
    end

    // Reference model state: previous winner, current lock holder and its streak, pending read.
    int        last_win  = 1;
    int        lock_port = -1;
    int        streak    = 0;
    bit        pend_valid = 0;
    int        pend_port = 0;
    bit [31:0] pend_data = 0;
    bit [31:0] golden [16384];

    function automatic port_in_t p_idle();
        port_in_t p = '0;
        return p;
    endfunction

    function automatic port_in_t p_rd(input logic [13:0] a, input logic lk);
        port_in_t p = '0;
        p.req = 1'b1; p.addr = a; p.lock = lk;
        return p;
    endfunction

    function automatic port_in_t p_wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
        port_in_t p = '0;
        p.req = 1'b1; p.we = 1'b1; p.addr = a; p.wdata = d; p.strb = s;
        return p;
    endfunction

    function automatic stim_t st(input logic r, input port_in_t a, input port_in_t b);
        stim_t s;
        s.rst = r; s.p0 = a; s.p1 = b;
        return s;
    endfunction

    function automatic exp_t e_idle(input logic [1:0] rv, input logic [31:0] r0, input logic [31:0] r1);
        exp_t e;
        e.gnt = 2'b00; e.ceb = 1'b1; e.web = 1'b1; e.bweb = 32'hFFFF_FFFF;
        e.a = '0; e.di = '0; e.rv = rv; e.rd0 = r0; e.rd1 = r1;
        return e;
    endfunction

    function automatic exp_t e_rd(input logic [1:0] g, input logic [13:0] a, input logic [1:0] rv,
                                  input logic [31:0] r0, input logic [31:0] r1);
        exp_t e = e_idle(rv, r0, r1);
        e.gnt = g; e.ceb = 1'b0; e.a = a;
        return e;
    endfunction

    function automatic exp_t e_wr(input logic [1:0] g, input logic [13:0] a, input logic [31:0] d,
                                  input logic [31:0] bw, input logic [1:0] rv,
                                  input logic [31:0] r0, input logic [31:0] r1);
        exp_t e = e_rd(g, a, rv, r0, r1);
        e.web = 1'b0; e.di = d; e.bweb = bw;
        return e;
    endfunction

    function automatic int modelPick(input logic r0, input logic r1);
        bit owner_req = (lock_port == 0) ? r0 : r1;
        if (lock_port >= 0 && streak < LOCK_MAX && owner_req) return lock_port;
        if (r0 && r1) return 1 - last_win;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic exp_t modelExpect(input stim_t s);
        exp_t     e;
        port_in_t w;
        int       win;
        logic [1:0] rv = 2'b00;
        if (!s.rst && pend_valid) rv = (pend_port == 0) ? 2'b01 : 2'b10;
        e = e_idle(rv, rv[0] ? pend_data : 32'h0, rv[1] ? pend_data : 32'h0);
        if (s.rst) return e;
        win = modelPick(s.p0.req, s.p1.req);
        if (win < 0) return e;
        w = (win == 0) ? s.p0 : s.p1;
        e.gnt = (win == 0) ? 2'b01 : 2'b10;
        e.ceb = 1'b0;
        e.a   = w.addr;
        if (w.we) begin
            e.web = 1'b0;
            e.di  = w.wdata;
            for (int i = 0; i < 4; i++) e.bweb[8*i +: 8] = w.strb[i] ? 8'h00 : 8'hFF;
        end
        return e;
    endfunction

    function automatic void modelAdvance(input stim_t s);
        port_in_t w;
        int       win;
        if (s.rst) begin
            last_win = 1; lock_port = -1; streak = 0; pend_valid = 0;
            return;
        end
        win = modelPick(s.p0.req, s.p1.req);
        pend_valid = 0;
        if (win < 0) begin
            lock_port = -1; streak = 0;
            return;
        end
        w = (win == 0) ? s.p0 : s.p1;
        last_win = win;
        if (w.lock) begin
            if (lock_port == win && streak < LOCK_MAX) streak++;
            else streak = 1;
            lock_port = win;
        end else begin
            lock_port = -1; streak = 0;
        end
        if (w.we) begin
            for (int i = 0; i < 4; i++)
                if (w.strb[i]) golden[w.addr][8*i +: 8] = w.wdata[8*i +: 8];
        end else begin
            pend_valid = 1; pend_port = win; pend_data = golden[w.addr];
        end
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst      = s.rst;
        m0_req   = s.p0.req;  m0_we = s.p0.we;  m0_lock = s.p0.lock;
        m0_addr  = s.p0.addr; m0_wstrb = s.p0.strb; m0_wdata = s.p0.wdata;
        m1_req   = s.p1.req;  m1_we = s.p1.we;  m1_lock = s.p1.lock;
        m1_addr  = s.p1.addr; m1_wstrb = s.p1.strb; m1_wdata = s.p1.wdata;
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        cmp({tag, ".gnt"},   32'({m1_gnt, m0_gnt}),       32'(e.gnt));
        cmp({tag, ".ceb"},   32'(sram_ceb),               32'(e.ceb));
        cmp({tag, ".web"},   32'(sram_web),               32'(e.web));
        cmp({tag, ".bweb"},  sram_bweb,                   e.bweb);
        cmp({tag, ".a"},     32'(sram_a),                 32'(e.a));
        cmp({tag, ".di"},    sram_di,                     e.di);
        cmp({tag, ".rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'(e.rv));
        cmp({tag, ".rdata0"}, m0_rdata,                   e.rd0);
        cmp({tag, ".rdata1"}, m1_rdata,                   e.rd1);
    endtask

    task automatic runModel(input string tag, input stim_t s);
        applyStimulus(s);
        checkOutput(tag, modelExpect(s));
        modelAdvance(s);
    endtask

    function automatic port_in_t randPort();
        port_in_t p;
        p.req   = ($urandom_range(0, 3) != 0);
        p.we    = $urandom_range(0, 1) == 1;
        p.lock  = ($urandom_range(0, 2) == 0);
        p.addr  = 14'($urandom_range(0, 7));
        p.strb  = 4'($urandom_range(0, 15));
        p.wdata = $urandom;
        return p;
    endfunction

    initial begin
        vec_t  tbl[$];
        stim_t s;

        rst = 1'b1;
        {m0_req, m0_we, m0_lock, m0_addr, m0_wstrb, m0_wdata} = '0;
        {m1_req, m1_we, m1_lock, m1_addr, m1_wstrb, m1_wdata} = '0;

        // Reset with requests pending, plain writes/reads and a conflicting write pair.
        tbl.push_back('{s: st(1, p_rd(ADR_A, 0), p_rd(ADR_B, 0)), e: e_idle(2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_wr(ADR_A, 32'hFFFF_FFFF, 4'hF), p_wr(ADR_B, 32'hAAAA_AAAA, 4'hF)),
                        e: e_wr(2'b01, ADR_A, 32'hFFFF_FFFF, 32'h0, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_wr(ADR_B, 32'hAAAA_AAAA, 4'hF)),
                        e: e_wr(2'b10, ADR_B, 32'hAAAA_AAAA, 32'h0, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_idle()), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b01, 32'hFFFF_FFFF, 0)});
        // Back-to-back conflicting reads right after reset alternate starting with port 0.
        tbl.push_back('{s: st(1, p_idle(), p_idle()), e: e_idle(2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 0)), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0)
                tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 0)),
                                e: e_rd(2'b10, ADR_B, 2'b01, 32'hFFFF_FFFF, 0)});
            else
                tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 0)),
                                e: e_rd(2'b01, ADR_A, 2'b10, 0, 32'hAAAA_AAAA)});
        end
        // Partial-strobe write over 0xAAAAAAAA, then read it back.
        tbl.push_back('{s: st(0, p_idle(), p_wr(ADR_B, 32'h1122_3344, 4'b0101)),
                        e: e_wr(2'b10, ADR_B, 32'h1122_3344, 32'hFF00_FF00, 2'b10, 0, 32'hAAAA_AAAA)});
        tbl.push_back('{s: st(0, p_idle(), p_rd(ADR_B, 0)), e: e_rd(2'b10, ADR_B, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b10, 0, 32'hAA22_AA44)});
        // Port 1 locks: after its first grant it holds four grants in a row, then port 0 wins.
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 1)), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 1)),
                        e: e_rd(2'b10, ADR_B, 2'b01, 32'hFFFF_FFFF, 0)});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 1)),
                            e: e_rd(2'b10, ADR_B, 2'b10, 0, 32'hAA22_AA44)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 1)),
                        e: e_rd(2'b01, ADR_A, 2'b10, 0, 32'hAA22_AA44)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b01, 32'hFFFF_FFFF, 0)});
        // A zero-strobe write still issues but leaves the word untouched.
        tbl.push_back('{s: st(0, p_wr(ADR_A, 32'h0, 4'h0), p_idle()),
                        e: e_wr(2'b01, ADR_A, 32'h0, 32'hFFFF_FFFF, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_idle()), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b01, 32'hFFFF_FFFF, 0)});
        // Reset lands in the cycle after a granted read: the response is dropped.
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_idle()), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        tbl.push_back('{s: st(1, p_rd(ADR_A, 0), p_rd(ADR_B, 0)), e: e_idle(2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 0)), e: e_rd(2'b01, ADR_A, 2'b00, 0, 0)});
        tbl.push_back('{s: st(0, p_idle(), p_idle()), e: e_idle(2'b01, 32'hFFFF_FFFF, 0)});

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("row%0d", i), tbl[i].e);
            modelAdvance(tbl[i].s);
        end

        for (int i = 0; i < N_RANDOM; i++) begin
            s.rst = ($urandom_range(0, 49) == 0);
            s.p0  = randPort();
            s.p1  = randPort();
            runModel($sformatf("rnd%0d", i), s);
        end

`ifdef DM_ARB_PERF_EN
        runModel("perf_rst", st(1, p_idle(), p_idle()));
        for (int i = 0; i < 10; i++)
            runModel($sformatf("perf%0d", i), st(0, p_rd(ADR_A, 0), p_rd(ADR_B, 0)));
        runModel("perf_idle", st(0, p_idle(), p_idle()));
        cmp("perf_conflict", perf_conflict, 32'd10);
        cmp("perf_gnt0", perf_gnt0, 32'd5);
        cmp("perf_gnt1", perf_gnt1, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
